// File: rtl/iter_multiplier.sv
// Iterative RV-style multiplier: retires BITS_PER_CYCLE multiplier bits per cycle into a
// 2*XLEN accumulator, applies the sign in a final fix-up cycle, then holds the result.
module iter_multiplier #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [3:0]      alu_op,
    input  logic            flush,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [XLEN-1:0] mul_result,
    output logic            busy
);

    localparam logic [3:0] ALU_MUL    = 4'h8;
    localparam logic [3:0] ALU_MULH   = 4'h9;
    localparam logic [3:0] ALU_MULHSU = 4'hA;
    localparam logic [3:0] ALU_MULHU  = 4'hB;

    localparam int unsigned BPC  = BITS_PER_CYCLE;
    localparam int unsigned AccW = 2 * XLEN;
    localparam int unsigned OffW = $clog2(XLEN);
    // Bit offset of the final multiplier chunk; reaching it ends CALC.
    localparam logic [OffW-1:0] LastOff = OffW'(XLEN - BPC);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e          state_q, state_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic [XLEN-1:0] a_mag_q, a_mag_d;
    logic [XLEN-1:0] b_rem_q, b_rem_d;
    logic [OffW-1:0] off_q, off_d;
    logic            sign_q, sign_d;
    logic            low_q, low_d;

    logic            op_known;
    logic            a_signed;
    logic            b_signed;
    logic            neg_a;
    logic            neg_b;
    logic            zero_in;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;

    always_comb begin
        op_known = 1'b1;
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (alu_op)
            ALU_MUL, ALU_MULHU: begin
                a_signed = 1'b0;
            end
            ALU_MULH: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            ALU_MULHSU: begin
                a_signed = 1'b1;
            end
            default: begin
                op_known = 1'b0;
            end
        endcase
        neg_a   = a_signed & operand_a[XLEN-1];
        neg_b   = b_signed & operand_b[XLEN-1];
        a_abs   = neg_a ? -operand_a : operand_a;
        b_abs   = neg_b ? -operand_b : operand_b;
        zero_in = (operand_a == '0) || (operand_b == '0);
    end

    logic [BPC-1:0]  chunk;
    logic [AccW-1:0] partial;

    always_comb begin
        chunk   = b_rem_q[BPC-1:0];
        partial = {{XLEN{1'b0}}, a_mag_q} * {{(AccW - BPC){1'b0}}, chunk};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_mag_d = a_mag_q;
        b_rem_d = b_rem_q;
        off_d   = off_q;
        sign_d  = sign_q;
        low_d   = low_q;

        unique case (state_q)
            StIdle: begin
                if (start_valid && start_ready) begin
                    acc_d   = '0;
                    off_d   = '0;
                    a_mag_d = a_abs;
                    b_rem_d = b_abs;
                    sign_d  = neg_a ^ neg_b;
                    low_d   = (alu_op == ALU_MUL);
                    // Zero operands and unknown ops skip straight to a zero result.
                    state_d = (!op_known || zero_in) ? StDone : StCalc;
                end
            end
            StCalc: begin
                acc_d   = acc_q + (partial << off_q);
                b_rem_d = b_rem_q >> BPC;
                off_d   = off_q + OffW'(BPC);
                if (off_q == LastOff) begin
                    off_d   = '0;
                    state_d = StFix;
                end
            end
            StFix: begin
                if (sign_q) begin
                    acc_d = -acc_q;
                end
                state_d = StDone;
            end
            StDone: begin
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
        endcase

        if (flush) begin
            state_d = StIdle;
            acc_d   = '0;
            off_d   = '0;
            sign_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            a_mag_q <= '0;
            b_rem_q <= '0;
            off_q   <= '0;
            sign_q  <= 1'b0;
            low_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_mag_q <= a_mag_d;
            b_rem_q <= b_rem_d;
            off_q   <= off_d;
            sign_q  <= sign_d;
            low_q   <= low_d;
        end
    end

    always_comb begin
        start_ready  = (state_q == StIdle) && !flush;
        busy         = (state_q != StIdle);
        result_valid = (state_q == StDone);
        mul_result   = '0;
        if (result_valid) begin
            mul_result = low_q ? acc_q[XLEN-1:0] : acc_q[AccW-1:XLEN];
        end
    end

endmodule

// File: tb/tb_iter_multiplier.sv
// Bench for iter_multiplier: three instances (1, 4 and 8 bits per cycle) each checked every
// cycle against a transaction-level model, plus directed vectors with literal expectations.
module tb_iter_multiplier;

    localparam logic [3:0] OP_MUL    = 4'h8;
    localparam logic [3:0] OP_MULH   = 4'h9;
    localparam logic [3:0] OP_MULHSU = 4'hA;
    localparam logic [3:0] OP_MULHU  = 4'hB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst, sv, fl, rr, sr, rv, bsy;
    logic [2:0][31:0] opa, opb, res;
    logic [2:0][3:0]  op;

    int vectors     = 0;
    int miscompares = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned Bpc = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
        iter_multiplier #(
            .XLEN          (32),
            .BITS_PER_CYCLE(Bpc)
        ) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .start_valid (sv[g]),
            .start_ready (sr[g]),
            .operand_a   (opa[g]),
            .operand_b   (opb[g]),
            .alu_op      (op[g]),
            .flush       (fl[g]),
            .result_valid(rv[g]),
            .result_ready(rr[g]),
            .mul_result  (res[g]),
            .busy        (bsy[g])
        );
    end

    function automatic int bpc(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 8);
    endfunction

    function automatic logic [31:0] ref_mul(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        sa = {{32{a[31]}}, a};
        ua = {32'd0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        case (o)
            OP_MUL:    begin p = ua * ub; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            default:   return 32'd0;
        endcase
    endfunction

    function automatic logic is_early(input logic [3:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
        return !(o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) || a == 0 || b == 0;
    endfunction

    // Model: 0 = idle, 1 = computing (countdown to result), 2 = holding result.
    int          mst [3];
    int          mcnt[3];
    logic [31:0] mres[3];
    bit          m_init[3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                mst[k]    = 0;
                mres[k]   = 32'd0;
                m_init[k] = 1'b1;
            end else if (fl[k]) begin
                mst[k] = 0;
            end else begin
                case (mst[k])
                    0: if (sv[k]) begin
                        mres[k] = ref_mul(op[k], opa[k], opb[k]);
                        if (is_early(op[k], opa[k], opb[k])) begin
                            mst[k] = 2;
                        end else begin
                            mst[k]  = 1;
                            mcnt[k] = 32 / bpc(k) + 1;
                        end
                    end
                    1: begin
                        mcnt[k]--;
                        if (mcnt[k] == 0) mst[k] = 2;
                    end
                    default: if (rr[k]) mst[k] = 0;
                endcase
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (m_init[k]) begin
                logic        ev, eb, er;
                logic [31:0] eres;
                ev   = (mst[k] == 2);
                eb   = (mst[k] != 0);
                er   = (mst[k] == 0) && !fl[k];
                eres = ev ? mres[k] : 32'd0;
                vectors++;
                if (rv[k] !== ev || bsy[k] !== eb || sr[k] !== er || res[k] !== eres) begin
                    miscompares++;
                    $display("FAIL cycle_check dut%0d t=%0t: got valid=%b busy=%b ready=%b res=%h, want valid=%b busy=%b ready=%b res=%h",
                             k, $time, rv[k], bsy[k], sr[k], res[k], ev, eb, er, eres);
                end
            end
        end
    end

    task automatic check(input string name, input int k, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h, want %h", name, k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present a request for one edge, then wait (bounded) for result_valid.
    task automatic launch(input int k, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
        op[k]  = o;
        opa[k] = a;
        opb[k] = b;
        sv[k]  = 1'b1;
        step();
        sv[k] = 1'b0;
        lat   = 1;
        while (!rv[k] && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic release_result(input int k);
        rr[k] = 1'b1;
        step();
        rr[k] = 1'b0;
    endtask

    task automatic run_op(input int k, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        launch(k, o, a, b, lat);
        check("result", k, {32'd0, res[k]}, {32'd0, exp_res});
        check("latency", k, 64'(lat), 64'(exp_lat));
        release_result(k);
    endtask

    task automatic check_idle(input string name, input int k);
        check({name, "_valid"}, k, 64'(rv[k]), 64'd0);
        check({name, "_busy"}, k, 64'(bsy[k]), 64'd0);
        check({name, "_result"}, k, {32'd0, res[k]}, 64'd0);
        check({name, "_ready"}, k, 64'(sr[k]), 64'd1);
    endtask

    initial begin
        int lat;
        int full;
        rst = 3'b111;
        sv  = '0;
        fl  = '0;
        rr  = '0;
        opa = '0;
        opb = '0;
        op  = '0;
        step();
        step();
        rst = 3'b000;
        for (int k = 0; k < 3; k++) check_idle("reset", k);

        for (int k = 0; k < 3; k++) begin
            full = 32 / bpc(k) + 2;
            run_op(k, OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, full);
            run_op(k, OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, full);
            run_op(k, OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, full);
            run_op(k, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, full);
            run_op(k, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, full);
            run_op(k, OP_MULHU,  32'd0,        32'hDEAD_BEEF, 32'd0, 1);
            run_op(k, 4'hF,      32'd5,        32'd6,         32'd0, 1);
            run_op(k, OP_MULHSU, 32'h1234_5678, 32'h9ABC_DEF0,
                   ref_mul(OP_MULHSU, 32'h1234_5678, 32'h9ABC_DEF0), full);
            run_op(k, OP_MULH,   32'h8000_0001, 32'h7FFF_FFFF,
                   ref_mul(OP_MULH, 32'h8000_0001, 32'h7FFF_FFFF), full);

            // Hold in DONE with result_ready low; a competing request must be ignored.
            launch(k, OP_MULH, 32'h8000_0000, 32'h8000_0000, lat);
            op[k]  = OP_MUL;
            opa[k] = 32'd9;
            opb[k] = 32'd9;
            sv[k]  = 1'b1;
            for (int i = 0; i < 10; i++) begin
                step();
                check("hold_result", k, {32'd0, res[k]}, 64'h4000_0000);
                check("hold_valid", k, 64'(rv[k]), 64'd1);
            end
            sv[k] = 1'b0;
            release_result(k);
            check_idle("after_release", k);

            // Reset in the middle of CALC.
            launch(k, OP_MUL, 32'hABCD_0123, 32'h0F0F_0F0F, lat);
            release_result(k);
            op[k]  = OP_MULH;
            opa[k] = 32'hFFFF_0000;
            opb[k] = 32'h1234_5678;
            sv[k]  = 1'b1;
            step();
            sv[k] = 1'b0;
            step();
            step();
            rst[k] = 1'b1;
            step();
            rst[k] = 1'b0;
            check_idle("mid_reset", k);
            run_op(k, OP_MUL, 32'd3, 32'd5, 32'd15, full);
        end

        // Flush at iteration 5, then an immediate new request.
        op[0]  = OP_MUL;
        opa[0] = 32'h0000_1234;
        opb[0] = 32'h0000_5678;
        sv[0]  = 1'b1;
        step();
        sv[0] = 1'b0;
        for (int i = 0; i < 4; i++) step();
        fl[0] = 1'b1;
        step();
        fl[0] = 1'b0;
        check("flush_busy", 0, 64'(bsy[0]), 64'd0);
        check("flush_valid", 0, 64'(rv[0]), 64'd0);
        run_op(0, OP_MUL, 32'd3, 32'd5, 32'd15, 34);

        // Flush beats a simultaneous request in IDLE.
        fl[0]  = 1'b1;
        sv[0]  = 1'b1;
        op[0]  = OP_MUL;
        opa[0] = 32'd2;
        opb[0] = 32'd2;
        step();
        fl[0] = 1'b0;
        sv[0] = 1'b0;
        check("flush_vs_accept", 0, 64'(bsy[0]), 64'd0);
        step();
        check("flush_vs_accept_late", 0, 64'(rv[0]), 64'd0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
